// File: rtl/cam_capture.sv
// Purpose: captures OV7670 parallel video (PCLK/VSYNC/HREF/D) into RGB565 pixels tagged with x/y and frame markers.
// Latency: outputs register two clk_i edges after the camera edge first lands in the synchronizer.
// Backpressure: none; pixels are push-only strobes, so the consumer must accept one per pixel.
module cam_capture #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   localparam int XW  = $clog2(H_ACTIVE),
   localparam int YW  = $clog2(V_ACTIVE),
   localparam int XCW = $clog2(H_ACTIVE + 1),
   localparam int YCW = $clog2(V_ACTIVE + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          setup_done_i,
   input  logic          cam_pclk_i,
   input  logic          cam_vsync_i,
   input  logic          cam_href_i,
   input  logic [7:0]    cam_data_i,
   output logic          pix_valid_o,
   output logic [15:0]   pix_data_o,
   output logic [XW-1:0] pix_x_o,
   output logic [YW-1:0] pix_y_o,
   output logic          frame_start_o,
   output logic          frame_end_o,
   output logic          frame_err_o
);

   localparam logic [XCW-1:0] H_MAX = XCW'(H_ACTIVE);
   localparam logic [YCW-1:0] V_MAX = YCW'(V_ACTIVE);

   typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACTIVE} state_t;

   state_t          state_q, state_d;
   logic [10:0]     s1_q, s2_q;          // {pclk, vsync, href, data}
   logic [2:0]      s3_q;                // {pclk, vsync, href}
   logic [XCW-1:0]  x_q, x_d;            // saturating pixel count in current line
   logic [YCW-1:0]  y_q, y_d;            // saturating line count in current frame
   logic            phase_q, phase_d;
   logic [7:0]      hi_q, hi_d;
   logic            err_q, err_d;
   logic            end_pend_q, end_pend_d;
   logic            pix_vld_q, pix_vld_d;
   logic [15:0]     pix_dat_q, pix_dat_d;
   logic [XW-1:0]   pix_x_q, pix_x_d;
   logic [YW-1:0]   pix_y_q, pix_y_d;
   logic            fs_q, fs_d, fe_q, fe_d, ferr_q, ferr_d;

   logic       pclk_rise, vsync_rise, vsync_fall, href_fall, byte_take, pix_done;
   logic [7:0] cam_byte;

   assign pclk_rise  =  s2_q[10] & ~s3_q[2];
   assign vsync_rise =  s2_q[9]  & ~s3_q[1];
   assign vsync_fall = ~s2_q[9]  &  s3_q[1];
   assign href_fall  = ~s2_q[8]  &  s3_q[0];
   assign cam_byte   =  s2_q[7:0];
   // A byte arriving in the same cycle HREF falls still belongs to the line.
   assign byte_take  = (state_q == ACTIVE) && !end_pend_q && pclk_rise && (s2_q[8] || s3_q[0]);
   assign pix_done   = byte_take && phase_q;

   // State, synchronizer and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q    <= IDLE;
         s1_q       <= '0;
         s2_q       <= '0;
         s3_q       <= '0;
         x_q        <= '0;
         y_q        <= '0;
         phase_q    <= 1'b0;
         hi_q       <= '0;
         err_q      <= 1'b0;
         end_pend_q <= 1'b0;
         pix_vld_q  <= 1'b0;
         pix_dat_q  <= '0;
         pix_x_q    <= '0;
         pix_y_q    <= '0;
         fs_q       <= 1'b0;
         fe_q       <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         s1_q       <= {cam_pclk_i, cam_vsync_i, cam_href_i, cam_data_i};
         s2_q       <= s1_q;
         s3_q       <= s2_q[10:8];
         x_q        <= x_d;
         y_q        <= y_d;
         phase_q    <= phase_d;
         hi_q       <= hi_d;
         err_q      <= err_d;
         end_pend_q <= end_pend_d;
         pix_vld_q  <= pix_vld_d;
         pix_dat_q  <= pix_dat_d;
         pix_x_q    <= pix_x_d;
         pix_y_q    <= pix_y_d;
         fs_q       <= fs_d;
         fe_q       <= fe_d;
         ferr_q     <= ferr_d;
      end
   end

   // Next-state: captures only start on a fresh VSYNC fall; losing setup always returns to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:       if (setup_done_i) state_d = WAIT_FRAME;
         WAIT_FRAME: if (vsync_fall) state_d = ACTIVE;
         ACTIVE:     if (end_pend_q || (vsync_rise && !pix_done)) state_d = WAIT_FRAME;
         default:    state_d = IDLE;
      endcase
      if (!setup_done_i) state_d = IDLE;
   end

   // Datapath and output strobes: byte packing, line/frame accounting and error tracking.
   always_comb begin
      x_d        = x_q;
      y_d        = y_q;
      phase_d    = phase_q;
      hi_d       = hi_q;
      err_d      = err_q;
      end_pend_d = 1'b0;
      pix_vld_d  = 1'b0;
      pix_dat_d  = pix_dat_q;
      pix_x_d    = pix_x_q;
      pix_y_d    = pix_y_q;
      fs_d       = 1'b0;
      fe_d       = 1'b0;
      ferr_d     = 1'b0;
      if (setup_done_i && state_q == WAIT_FRAME && vsync_fall) begin
         fs_d    = 1'b1;
         x_d     = '0;
         y_d     = '0;
         phase_d = 1'b0;
         err_d   = 1'b0;
      end
      if (setup_done_i && state_q == ACTIVE) begin
         if (end_pend_q) begin
            // Deferred frame end: the colliding pixel went out last cycle.
            fe_d   = 1'b1;
            ferr_d = err_q || (y_q != V_MAX);
         end else begin
            if (byte_take && !phase_q) begin
               hi_d    = cam_byte;
               phase_d = 1'b1;
            end else if (byte_take) begin
               phase_d = 1'b0;
               if (x_q < H_MAX && y_q < V_MAX) begin
                  pix_vld_d = 1'b1;
                  pix_dat_d = {hi_q, cam_byte};
                  pix_x_d   = x_q[XW-1:0];
                  pix_y_d   = y_q[YW-1:0];
               end else begin
                  err_d = 1'b1;
               end
               if (x_q < H_MAX) x_d = x_q + XCW'(1);
            end
            if (href_fall) begin
               if (phase_d || x_d != H_MAX) err_d = 1'b1;
               x_d     = '0;
               phase_d = 1'b0;
               if (y_q < V_MAX) y_d = y_q + YCW'(1);
            end
            if (vsync_rise && pix_done) begin
               end_pend_d = 1'b1;
            end else if (vsync_rise) begin
               fe_d   = 1'b1;
               ferr_d = err_d || (y_d != V_MAX);
            end
         end
      end
   end

   assign pix_valid_o   = pix_vld_q;
   assign pix_data_o    = pix_dat_q;
   assign pix_x_o       = pix_x_q;
   assign pix_y_o       = pix_y_q;
   assign frame_start_o = fs_q;
   assign frame_end_o   = fe_q;
   assign frame_err_o   = ferr_q;

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture with a 4x2 frame and PCLK at clk/4.
// Inputs are driven on the falling clk edge; outputs are observed 1ns after the rising edge.
// A monitor tallies strobes; each scenario task compares tallies against hand-derived counts.
module tb_cam_capture;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        setup_done_i = 1'b0;
   logic        cam_pclk_i = 1'b0;
   logic        cam_vsync_i = 1'b1;
   logic        cam_href_i = 1'b0;
   logic [7:0]  cam_data_i = 8'h00;
   logic        pix_valid_o;
   logic [15:0] pix_data_o;
   logic [1:0]  pix_x_o;
   logic [0:0]  pix_y_o;
   logic        frame_start_o, frame_end_o, frame_err_o;

   int n_checks = 0;
   int n_fail   = 0;
   int bidx     = 0;

   int          pv_total = 0, fs_total = 0, fe_total = 0, ferr_total = 0, ferr_lone = 0;
   logic [15:0] mon_dat [64];
   logic [1:0]  mon_x   [64];
   logic [0:0]  mon_y   [64];

   cam_capture #(.H_ACTIVE(4), .V_ACTIVE(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .setup_done_i(setup_done_i),
      .cam_pclk_i(cam_pclk_i), .cam_vsync_i(cam_vsync_i), .cam_href_i(cam_href_i),
      .cam_data_i(cam_data_i), .pix_valid_o(pix_valid_o), .pix_data_o(pix_data_o),
      .pix_x_o(pix_x_o), .pix_y_o(pix_y_o), .frame_start_o(frame_start_o),
      .frame_end_o(frame_end_o), .frame_err_o(frame_err_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      #1;
      if (pix_valid_o) begin
         mon_dat[pv_total % 64] = pix_data_o;
         mon_x[pv_total % 64]   = pix_x_o;
         mon_y[pv_total % 64]   = pix_y_o;
         pv_total++;
      end
      if (frame_start_o) fs_total++;
      if (frame_end_o) fe_total++;
      if (frame_err_o) ferr_total++;
      if (frame_err_o && !frame_end_o) ferr_lone++;
   end

   // Camera byte stream: 0x12, 0x34, 0x56, ... (step 0x22, wrapping).
   function automatic logic [7:0] bv(input int k);
      return 8'h12 + 8'(k * 34);
   endfunction

   function automatic logic [15:0] exp_pix(input int k);
      return {bv(k), bv(k + 1)};
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic send_byte();
      cam_pclk_i = 1'b0;
      cam_data_i = bv(bidx);
      bidx++;
      cyc(2);
      cam_pclk_i = 1'b1;
      cyc(2);
   endtask

   task automatic send_line(input int nbytes);
      cam_href_i = 1'b1;
      repeat (nbytes) send_byte();
      cam_pclk_i = 1'b0;
      cam_href_i = 1'b0;
      cyc(6);
   endtask

   task automatic frame_open();
      cam_vsync_i = 1'b0;
      cyc(6);
   endtask

   task automatic frame_close();
      cam_vsync_i = 1'b1;
      cyc(8);
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      setup_done_i = 1'b0;
      cyc(3);
      n_checks++; if (pix_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_pix_valid: got %b want 0", pix_valid_o); end
      n_checks++; if (pix_data_o !== 16'h0) begin n_fail++; $display("FAIL reset_pix_data: got %h want 0000", pix_data_o); end
      n_checks++; if (pix_x_o !== 2'd0) begin n_fail++; $display("FAIL reset_pix_x: got %0d want 0", pix_x_o); end
      n_checks++; if (pix_y_o !== 1'd0) begin n_fail++; $display("FAIL reset_pix_y: got %0d want 0", pix_y_o); end
      n_checks++; if (frame_start_o !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: got %b want 0", frame_start_o); end
      n_checks++; if (frame_end_o !== 1'b0) begin n_fail++; $display("FAIL reset_frame_end: got %b want 0", frame_end_o); end
      n_checks++; if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err_o); end
      rst_i = 1'b1;
      setup_done_i = 1'b1;
      cyc(4);
   endtask

   task automatic test_latency();
      int b0;
      cam_vsync_i = 1'b1;
      cyc(6);
      cam_vsync_i = 1'b0;
      @(posedge clk_i);                // edge N: s1 takes VSYNC low
      @(posedge clk_i); #1;            // edge N+1
      n_checks++; if (frame_start_o !== 1'b0) begin n_fail++; $display("FAIL lat_fs_early: got %b want 0", frame_start_o); end
      @(posedge clk_i); #1;            // edge N+2
      n_checks++; if (frame_start_o !== 1'b1) begin n_fail++; $display("FAIL lat_fs_n2: got %b want 1", frame_start_o); end
      @(posedge clk_i); #1;
      n_checks++; if (frame_start_o !== 1'b0) begin n_fail++; $display("FAIL lat_fs_width: got %b want 0", frame_start_o); end
      @(negedge clk_i);
      b0 = bidx;
      cam_href_i = 1'b1;
      send_byte();
      cam_pclk_i = 1'b0;
      cam_data_i = bv(bidx);
      bidx++;
      cyc(2);
      cam_pclk_i = 1'b1;
      @(posedge clk_i);                // edge N: s1 takes PCLK high
      @(posedge clk_i); #1;
      n_checks++; if (pix_valid_o !== 1'b0) begin n_fail++; $display("FAIL lat_pv_early: got %b want 0", pix_valid_o); end
      @(posedge clk_i); #1;
      n_checks++; if (pix_valid_o !== 1'b1) begin n_fail++; $display("FAIL lat_pv_n2: got %b want 1", pix_valid_o); end
      n_checks++; if (pix_data_o !== exp_pix(b0)) begin n_fail++; $display("FAIL lat_pix_data: got %h want %h", pix_data_o, exp_pix(b0)); end
      @(posedge clk_i); #1;
      n_checks++; if (pix_valid_o !== 1'b0) begin n_fail++; $display("FAIL lat_pv_width: got %b want 0", pix_valid_o); end
      n_checks++; if (pix_data_o !== exp_pix(b0)) begin n_fail++; $display("FAIL lat_pix_hold: got %h want %h", pix_data_o, exp_pix(b0)); end
      @(negedge clk_i);
      cam_pclk_i = 1'b0;
      cam_href_i = 1'b0;
      cyc(6);
      frame_close();
   endtask

   task automatic test_nominal();
      int pv0, fs0, fe0, er0, b0, i;
      pv0 = pv_total; fs0 = fs_total; fe0 = fe_total; er0 = ferr_total;
      frame_open();
      b0 = bidx;
      send_line(8);
      send_line(8);
      frame_close();
      n_checks++; if (pv_total - pv0 !== 8) begin n_fail++; $display("FAIL nom_pix_count: got %0d want 8", pv_total - pv0); end
      for (i = 0; i < 8; i++) begin
         n_checks++; if (mon_dat[(pv0 + i) % 64] !== exp_pix(b0 + 2 * i)) begin n_fail++; $display("FAIL nom_pix_data[%0d]: got %h want %h", i, mon_dat[(pv0 + i) % 64], exp_pix(b0 + 2 * i)); end
         n_checks++; if (mon_x[(pv0 + i) % 64] !== 2'(i % 4)) begin n_fail++; $display("FAIL nom_pix_x[%0d]: got %0d want %0d", i, mon_x[(pv0 + i) % 64], i % 4); end
         n_checks++; if (mon_y[(pv0 + i) % 64] !== 1'(i / 4)) begin n_fail++; $display("FAIL nom_pix_y[%0d]: got %0d want %0d", i, mon_y[(pv0 + i) % 64], i / 4); end
      end
      n_checks++; if (fs_total - fs0 !== 1) begin n_fail++; $display("FAIL nom_frame_start: got %0d want 1", fs_total - fs0); end
      n_checks++; if (fe_total - fe0 !== 1) begin n_fail++; $display("FAIL nom_frame_end: got %0d want 1", fe_total - fe0); end
      n_checks++; if (ferr_total - er0 !== 0) begin n_fail++; $display("FAIL nom_frame_err: got %0d want 0", ferr_total - er0); end
   endtask

   task automatic test_short_line();
      int pv0, fe0, er0;
      pv0 = pv_total; fe0 = fe_total; er0 = ferr_total;
      frame_open();
      send_line(8);
      send_line(6);
      frame_close();
      n_checks++; if (pv_total - pv0 !== 7) begin n_fail++; $display("FAIL short_pix_count: got %0d want 7", pv_total - pv0); end
      n_checks++; if (fe_total - fe0 !== 1) begin n_fail++; $display("FAIL short_frame_end: got %0d want 1", fe_total - fe0); end
      n_checks++; if (ferr_total - er0 !== 1) begin n_fail++; $display("FAIL short_frame_err: got %0d want 1", ferr_total - er0); end
      n_checks++; if (ferr_lone !== 0) begin n_fail++; $display("FAIL short_err_alone: got %0d want 0", ferr_lone); end
   endtask

   task automatic test_odd_long();
      int pv0, er0, b0;
      pv0 = pv_total; er0 = ferr_total;
      frame_open();
      b0 = bidx;
      send_line(9);
      send_line(12);
      frame_close();
      n_checks++; if (pv_total - pv0 !== 8) begin n_fail++; $display("FAIL odd_pix_count: got %0d want 8", pv_total - pv0); end
      n_checks++; if (mon_dat[(pv0 + 3) % 64] !== exp_pix(b0 + 6)) begin n_fail++; $display("FAIL odd_last_pix: got %h want %h", mon_dat[(pv0 + 3) % 64], exp_pix(b0 + 6)); end
      n_checks++; if (mon_dat[(pv0 + 4) % 64] !== exp_pix(b0 + 9)) begin n_fail++; $display("FAIL odd_realign: got %h want %h", mon_dat[(pv0 + 4) % 64], exp_pix(b0 + 9)); end
      n_checks++; if (mon_x[(pv0 + 4) % 64] !== 2'd0) begin n_fail++; $display("FAIL odd_realign_x: got %0d want 0", mon_x[(pv0 + 4) % 64]); end
      n_checks++; if (mon_x[(pv0 + 7) % 64] !== 2'd3) begin n_fail++; $display("FAIL long_last_x: got %0d want 3", mon_x[(pv0 + 7) % 64]); end
      n_checks++; if (mon_y[(pv0 + 7) % 64] !== 1'd1) begin n_fail++; $display("FAIL long_last_y: got %0d want 1", mon_y[(pv0 + 7) % 64]); end
      n_checks++; if (pix_x_o !== 2'd3) begin n_fail++; $display("FAIL long_x_hold: got %0d want 3", pix_x_o); end
      n_checks++; if (ferr_total - er0 !== 1) begin n_fail++; $display("FAIL odd_long_err: got %0d want 1", ferr_total - er0); end
   endtask

   task automatic test_extra_line();
      int pv0, fe0, er0;
      pv0 = pv_total; fe0 = fe_total; er0 = ferr_total;
      frame_open();
      send_line(8);
      send_line(8);
      send_line(8);
      frame_close();
      n_checks++; if (pv_total - pv0 !== 8) begin n_fail++; $display("FAIL extra_pix_count: got %0d want 8", pv_total - pv0); end
      n_checks++; if (fe_total - fe0 !== 1) begin n_fail++; $display("FAIL extra_frame_end: got %0d want 1", fe_total - fe0); end
      n_checks++; if (ferr_total - er0 !== 1) begin n_fail++; $display("FAIL extra_frame_err: got %0d want 1", ferr_total - er0); end
   endtask

   task automatic test_setup_gating();
      int pv0, fs0, fe0;
      setup_done_i = 1'b0;
      cyc(4);
      pv0 = pv_total; fs0 = fs_total; fe0 = fe_total;
      frame_open();
      send_line(4);
      setup_done_i = 1'b1;
      send_line(8);
      send_line(8);
      frame_close();
      n_checks++; if (pv_total - pv0 !== 0) begin n_fail++; $display("FAIL gate_pix_count: got %0d want 0", pv_total - pv0); end
      n_checks++; if (fs_total - fs0 !== 0) begin n_fail++; $display("FAIL gate_frame_start: got %0d want 0", fs_total - fs0); end
      n_checks++; if (fe_total - fe0 !== 0) begin n_fail++; $display("FAIL gate_frame_end: got %0d want 0", fe_total - fe0); end
   endtask

   task automatic test_abort();
      int pv0, fe0, er0, b0;
      frame_open();
      cam_href_i = 1'b1;
      repeat (3) send_byte();
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      n_checks++; if (pix_valid_o !== 1'b0) begin n_fail++; $display("FAIL abort_pix_valid: got %b want 0", pix_valid_o); end
      n_checks++; if (pix_data_o !== 16'h0) begin n_fail++; $display("FAIL abort_pix_data: got %h want 0000", pix_data_o); end
      n_checks++; if (frame_start_o !== 1'b0 || frame_end_o !== 1'b0 || frame_err_o !== 1'b0) begin n_fail++; $display("FAIL abort_frame_flags: got %b%b%b want 000", frame_start_o, frame_end_o, frame_err_o); end
      @(negedge clk_i);
      rst_i = 1'b1;
      pv0 = pv_total; fe0 = fe_total;
      repeat (5) send_byte();
      cam_pclk_i = 1'b0;
      cam_href_i = 1'b0;
      cyc(6);
      send_line(8);
      frame_close();
      n_checks++; if (pv_total - pv0 !== 0) begin n_fail++; $display("FAIL abort_no_pix: got %0d want 0", pv_total - pv0); end
      n_checks++; if (fe_total - fe0 !== 0) begin n_fail++; $display("FAIL abort_no_end: got %0d want 0", fe_total - fe0); end
      pv0 = pv_total; fe0 = fe_total; er0 = ferr_total;
      frame_open();
      b0 = bidx;
      send_line(8);
      send_line(8);
      frame_close();
      n_checks++; if (pv_total - pv0 !== 8) begin n_fail++; $display("FAIL resume_pix_count: got %0d want 8", pv_total - pv0); end
      n_checks++; if (mon_x[pv0 % 64] !== 2'd0 || mon_y[pv0 % 64] !== 1'd0) begin n_fail++; $display("FAIL resume_origin: got (%0d,%0d) want (0,0)", mon_x[pv0 % 64], mon_y[pv0 % 64]); end
      n_checks++; if (mon_dat[pv0 % 64] !== exp_pix(b0)) begin n_fail++; $display("FAIL resume_pix_data: got %h want %h", mon_dat[pv0 % 64], exp_pix(b0)); end
      n_checks++; if (fe_total - fe0 !== 1) begin n_fail++; $display("FAIL resume_frame_end: got %0d want 1", fe_total - fe0); end
      n_checks++; if (ferr_total - er0 !== 0) begin n_fail++; $display("FAIL resume_frame_err: got %0d want 0", ferr_total - er0); end
   endtask

   initial begin
      @(negedge clk_i);
      test_reset();
      test_latency();
      test_nominal();
      test_short_line();
      test_odd_long();
      test_extra_line();
      test_setup_gating();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
